// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the instruction word width, the sequential PC increment and a
// small alignment helper used on redirect targets.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // REQ   : request outstanding, result will be kept
    // DRAIN : request outstanding, result will be dropped (redirect seen)
    // FULL  : instruction word held for the decoder, no request
    // ERR   : misaligned redirect seen, unit is parked until reset
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_FULL  = 2'd2,
        S_ERR   = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    // A fetch address is legal only when it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Single-entry instruction fetch stage. Issues one instruction memory read at
// a time, holds the returned word for the decoder until it is accepted, and
// follows control-flow redirects. A redirect that arrives while a read is in
// flight waits for that read to complete and drops its data. A misaligned
// redirect target parks the unit in a sticky error state until reset.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   mem_req      out  1   memory read request (high in REQ and DRAIN)
//   mem_addr     out  32  byte address of the outstanding read
//   mem_ack      in   1   single-cycle read response strobe
//   mem_rdata    in   32  read data, valid with mem_ack
//   instr        out  32  instruction word for the decoder
//   instr_pc     out  32  address of instr
//   instr_valid  out  1   instr / instr_pc valid
//   instr_ready  in   1   decoder accepts instr this cycle
//   redirect     in   1   control-flow change
//   redirect_pc  in   32  new fetch address, valid with redirect
//   fetch_err    out  1   sticky misaligned-redirect error
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               fetch_err
);

    fetch_state_e       state_q,       state_d;
    logic [31:0]        fetch_pc_q,    fetch_pc_d;
    logic [31:0]        pend_pc_q,     pend_pc_d;
    logic               pend_bad_q,    pend_bad_d;
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [31:0]        instr_pc_q,    instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               fetch_err_q,   fetch_err_d;

    // Effective redirect target while draining: a new redirect replaces the
    // stored one (latest wins).
    logic [31:0] drain_pc;
    logic        drain_bad;

    assign drain_pc  = redirect ? redirect_pc                : pend_pc_q;
    assign drain_bad = redirect ? is_misaligned(redirect_pc) : pend_bad_q;

    always_comb begin
        // NOTE: every next-state signal gets a hold default before the case
        // so that no path through it leaves a value unassigned (no latches).
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        pend_bad_d    = pend_bad_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    if (mem_ack) begin
                        // Read completes this cycle: drop it and retarget now.
                        if (is_misaligned(redirect_pc)) begin
                            state_d     = S_ERR;
                            fetch_err_d = 1'b1;
                        end else begin
                            fetch_pc_d = redirect_pc;
                        end
                    end else begin
                        // Read still in flight: remember target, keep mem_addr.
                        pend_pc_d  = redirect_pc;
                        pend_bad_d = is_misaligned(redirect_pc);
                        state_d    = S_DRAIN;
                    end
                end else if (mem_ack) begin
                    instr_d       = mem_rdata;
                    instr_pc_d    = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    fetch_pc_d    = fetch_pc_q + PC_INC;
                    state_d       = S_FULL;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    pend_pc_d  = redirect_pc;
                    pend_bad_d = is_misaligned(redirect_pc);
                end
                if (mem_ack) begin
                    pend_bad_d = 1'b0;
                    if (drain_bad) begin
                        state_d     = S_ERR;
                        fetch_err_d = 1'b1;
                    end else begin
                        fetch_pc_d = drain_pc;
                        state_d    = S_REQ;
                    end
                end
            end

            S_FULL: begin
                // Redirect squashes the held word even if the decoder is ready.
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    if (is_misaligned(redirect_pc)) begin
                        state_d     = S_ERR;
                        fetch_err_d = 1'b1;
                    end else begin
                        fetch_pc_d = redirect_pc;
                        state_d    = S_REQ;
                    end
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end

            S_ERR: begin
                // Parked until reset; all other inputs ignored.
            end

            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            pend_pc_q     <= '0;
            pend_bad_q    <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_pc_q     <= pend_pc_d;
            pend_bad_q    <= pend_bad_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Request and valid are forced low while rst is held, including the
    // cycles after the reset edge when the state already reads REQ.
    assign mem_req     = ~rst & ((state_q == S_REQ) || (state_q == S_DRAIN));
    assign mem_addr    = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = ~rst & instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level model built
// from a held-word queue, an error flag and a "drop next response" marker.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } held_t;

    held_t       held[$];      // word waiting for the decoder (0 or 1 entries)
    bit          m_err;        // sticky misaligned-redirect error
    logic [31:0] m_pc;         // next / outstanding fetch address
    bit          m_drop;       // the outstanding response must be discarded
    logic [31:0] m_tgt;        // where to go once the dropped response arrives

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    function automatic bit m_requesting();
        return !m_err && (held.size() == 0);
    endfunction

    task automatic model_step(input bit r, input bit a, input logic [31:0] rd,
                              input bit rdy, input bit rdr, input logic [31:0] rpc);
        if (r) begin
            held.delete();
            m_err  = 0;
            m_pc   = 32'h0;
            m_drop = 0;
            m_tgt  = 32'h0;
        end else if (m_err) begin
            // parked
        end else if (held.size() != 0) begin
            if (rdr) begin
                void'(held.pop_front());
                if (bad_addr(rpc)) m_err = 1;
                else               m_pc  = rpc;
            end else if (rdy) begin
                void'(held.pop_front());
            end
        end else if (m_drop) begin
            if (rdr) m_tgt = rpc;
            if (a) begin
                m_drop = 0;
                if (bad_addr(m_tgt)) m_err = 1;
                else                 m_pc  = m_tgt;
            end
        end else if (rdr) begin
            if (a) begin
                if (bad_addr(rpc)) m_err = 1;
                else               m_pc  = rpc;
            end else begin
                m_drop = 1;
                m_tgt  = rpc;
            end
        end else if (a) begin
            held.push_back('{word: rd, pc: m_pc});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_model();
        bit exp_req;
        bit exp_valid;
        exp_req   = !rst && m_requesting();
        exp_valid = !rst && (held.size() != 0);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", mem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("instr", instr, held[0].word);
            check("instr_pc", instr_pc, held[0].pc);
        end
        check("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input bit r, input bit a, input logic [31:0] rd,
                        input bit rdy, input bit rdr, input logic [31:0] rpc);
        rst         = r;
        mem_ack     = a;
        mem_rdata   = rd;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        model_step(r, a, rd, rdy, rdr, rpc);
        #1;
        compare_model();
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_err = 0; m_pc = '0; m_drop = 0; m_tgt = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'hBAD0_BAD0, 1, 0, 0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // First fetch after reset, ack in first post-reset cycle
        step(0, 0, 0, 1, 0, 0);
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", mem_addr, 32'h0);
        step(0, 1, 32'h0010_0093, 1, 0, 0);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'h0010_0093);
        check("first_pc", instr_pc, 32'h0);

        // Decoder stalls for 5 cycles, then accepts
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("stall_instr", instr, 32'h0010_0093);
            check("stall_req", 32'(mem_req), 32'd0);
        end
        step(0, 0, 0, 1, 0, 0);
        check("accept_req", 32'(mem_req), 32'd1);
        check("accept_addr", mem_addr, 32'h4);

        // Fetch addr 4, accept, now requesting addr 8
        step(0, 1, 32'h1111_1111, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("addr8", mem_addr, 32'h8);

        // Redirect while request at 8 is outstanding
        step(0, 0, 0, 0, 1, 32'h0000_0100);
        check("drain_addr", mem_addr, 32'h8);
        step(0, 0, 0, 0, 0, 0);
        check("drain_addr2", mem_addr, 32'h8);
        step(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        check("drain_drop", 32'(instr_valid), 32'd0);
        check("drain_target", mem_addr, 32'h100);

        // Redirect in FULL beats instr_ready
        step(0, 1, 32'h2222_2222, 0, 0, 0);
        check("full_pc", instr_pc, 32'h100);
        step(0, 0, 0, 1, 1, 32'h0000_0200);
        check("squash_valid", 32'(instr_valid), 32'd0);
        check("squash_addr", mem_addr, 32'h200);

        // Wrap of the sequential PC
        step(0, 1, 32'h3333_3333, 0, 1, 32'hFFFF_FFFC);
        check("wrap_setup", mem_addr, 32'hFFFF_FFFC);
        step(0, 1, 32'h4444_4444, 0, 0, 0);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 0, 0);
        check("wrap_addr", mem_addr, 32'h0);

        // Misaligned redirect with no request outstanding
        step(0, 1, 32'h5555_5555, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0102);
        check("err_flag", 32'(fetch_err), 32'd1);
        check("err_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h6666_6666, 1, 1, 32'h40);
        check("err_sticky", 32'(fetch_err), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        check("err_cleared", 32'(fetch_err), 32'd0);

        // Misaligned redirect while a request is outstanding
        step(0, 0, 0, 0, 1, 32'h0000_0013);
        check("err_pend_noflag", 32'(fetch_err), 32'd0);
        step(0, 1, 32'h7777_7777, 0, 0, 0);
        check("err_after_ack", 32'(fetch_err), 32'd1);
        step(1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bit          r, a, rdy, rdr;
            logic [31:0] rd, rpc;
            r   = ($urandom_range(0, 149) == 0) || (m_err && $urandom_range(0, 9) == 0);
            a   = m_requesting() && ($urandom_range(0, 1) == 1);
            rd  = $urandom;
            rdy = ($urandom_range(0, 1) == 1);
            rdr = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0:       rpc = $urandom;                                  // may be misaligned
                1:       rpc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
                default: rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; // aligned
            endcase
            step(r, a, rd, rdy, rdr, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
